// File: rtl/switch_conditioner.sv
// Board slide-switch conditioner: per-bit synchroniser and debounce feeding the CPU's
// switches port, with a registered per-bit change mask and an OR-reduced change strobe.
module switch_conditioner_bit #(
  parameter int       SYNC_STAGES     = 2,
  parameter int       DEBOUNCE_CYCLES = 16,
  parameter int       CW              = 5,
  parameter logic     RST_BIT         = 1'b0
) (
  input  logic boardCLK,
  input  logic reset,
  input  logic sampleTick,
  input  logic rawBit,
  output logic cleanBit,
  output logic changeBit
);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   chg_q, chg_d;
  logic                   syncBit;

  assign syncBit = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], rawBit};

  // A return to the clean level discards any partial count; the counter never passes LAST.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
    if (syncBit == clean_q) begin
      cnt_d = '0;
    end else if (sampleTick) begin
      if (cnt_q == LAST) begin
        clean_d = syncBit;
        cnt_d   = '0;
        chg_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge boardCLK or negedge reset) begin
    if (!reset) begin
      sync_q  <= {SYNC_STAGES{RST_BIT}};
      cnt_q   <= '0;
      clean_q <= RST_BIT;
      chg_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      chg_q   <= chg_d;
    end
  end

  assign cleanBit  = clean_q;
  assign changeBit = chg_q;
endmodule

module switch_conditioner #(
  parameter int               WIDTH           = 8,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             boardCLK,
  input  logic             reset,
  input  logic             sampleTick,
  input  logic [WIDTH-1:0] switchesRaw,
  output logic [WIDTH-1:0] switchesClean,
  output logic [WIDTH-1:0] changeMask,
  output logic             switchesChanged
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_conditioner_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CW             (CW),
      .RST_BIT        (RESET_VALUE[i])
    ) u_bit (
      .boardCLK  (boardCLK),
      .reset     (reset),
      .sampleTick(sampleTick),
      .rawBit    (switchesRaw[i]),
      .cleanBit  (switchesClean[i]),
      .changeBit (changeMask[i])
    );
  end

  assign switchesChanged = |changeMask;
endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_switch_conditioner;
  logic       boardCLK = 1'b0;
  logic       reset;
  logic       sampleTick;
  logic [7:0] switchesRaw;
  logic [7:0] switchesClean;
  logic [7:0] changeMask;
  logic       switchesChanged;

  int n_cmp = 0;
  int n_err = 0;

  switch_conditioner #(
    .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_VALUE(8'h00)
  ) dut (
    .boardCLK       (boardCLK),
    .reset          (reset),
    .sampleTick     (sampleTick),
    .switchesRaw    (switchesRaw),
    .switchesClean  (switchesClean),
    .changeMask     (changeMask),
    .switchesChanged(switchesChanged)
  );

  always #5 boardCLK = ~boardCLK;

  task automatic tick();
    @(posedge boardCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c, input logic [7:0] m);
    chk({tag, ".clean"}, switchesClean, c);
    chk({tag, ".mask"}, changeMask, m);
    chk({tag, ".chg"}, 8'(switchesChanged), (m != 8'h00) ? 8'h01 : 8'h00);
  endtask

  initial begin
    // 1: reset held with all switches high, then release
    reset = 1'b0; sampleTick = 1'b1; switchesRaw = 8'hFF;
    #3;
    chk_all("rst_async", 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("rst_hold", 8'h00, 8'h00);
    end
    reset = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk_all("rel_wait", 8'h00, 8'h00);
    end
    tick();
    chk_all("rel_upd", 8'hFF, 8'hFF);
    tick();
    chk_all("rel_after", 8'hFF, 8'h00);

    // settle back to all-low
    switchesRaw = 8'h00;
    for (int i = 0; i < 10; i++) tick();
    chk_all("settle0", 8'h00, 8'h00);

    // 2: clean edge on bit 0
    switchesRaw = 8'h01;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk_all("b0_wait", 8'h00, 8'h00);
    end
    tick();
    chk_all("b0_upd", 8'h01, 8'h01);
    tick();
    chk_all("b0_after", 8'h01, 8'h00);

    // 3: bit 3 bounces 3 high / 1 low / 3 high, then low
    for (int n = 0; n < 8; n++) begin
      switchesRaw = (n < 3 || (n >= 4 && n < 7)) ? 8'h09 : 8'h01;
      tick();
      chk_all("bounce", 8'h01, 8'h00);
    end
    for (int n = 0; n < 6; n++) begin
      tick();
      chk_all("bounce_tail", 8'h01, 8'h00);
    end

    // 4: sampleTick high one cycle in four
    switchesRaw = 8'h81;
    for (int n = 1; n <= 20; n++) begin
      sampleTick = (n % 4 == 0);
      tick();
      if (n < 16)       chk_all("gate_wait", 8'h01, 8'h00);
      else if (n == 16) chk_all("gate_upd", 8'h81, 8'h80);
      else              chk_all("gate_after", 8'h81, 8'h00);
    end
    sampleTick = 1'b1;

    // 5: bits 2..5 rise (bits 0,7 fall); reset mid-count between edges
    switchesRaw = 8'h3C;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk_all("multi_cnt", 8'h81, 8'h00);
    end
    #3 reset = 1'b0;
    #1;
    chk_all("mid_rst", 8'h00, 8'h00);
    tick();
    chk_all("mid_rst_hold", 8'h00, 8'h00);
    reset = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk_all("multi_wait", 8'h00, 8'h00);
    end
    tick();
    chk_all("multi_upd", 8'h3C, 8'h3C);
    tick();
    chk_all("multi_after", 8'h3C, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
